// File: rtl/dp_seq_pkg.sv
// Shared definitions for the datapath micro-sequencer: FSM states, control-word
// field positions, the idle control word and status-flag bit positions.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_DONE = 3'd3,
    ST_HALT = 3'd4
  } seq_state_e;

  // Control word layout: {DA[15:13], AA[12:10], BA[9:7], bit6, FS/MD[5:1], bit0}
  localparam int CW_DA_LSB = 13;
  localparam int CW_AA_LSB = 10;
  localparam int CW_BA_LSB = 7;
  localparam int CW_FS_LSB = 1;

  localparam logic [15:0] DP_NOP_CW = 16'h0000;

  // Bit positions inside the {C,V,D,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_D = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

endpackage

// File: rtl/seq_prog_ram.sv
// Program store: DEPTH control words, one synchronous write port and one
// asynchronous read port so a word written on an edge is readable right after it.
module seq_prog_ram #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CW_W   = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [CW_W-1:0]   wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [CW_W-1:0]   rdata_o
);

  logic [CW_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-sequencer feeding the register-file datapath: stores a short program and
// issues it free-running or single-stepped, halting on a masked status-flag condition.
module datapath_sequencer
  import dp_seq_pkg::*;
#(
  parameter int              DEPTH  = 8,
  parameter int              ADDR_W = 3,
  parameter int              CW_W   = 16,
  parameter logic [CW_W-1:0] NOP_CW = CW_W'(DP_NOP_CW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [CW_W-1:0]   prog_data,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic              run,
  input  logic              step,
  input  logic              stop,
  input  logic [3:0]        flag_mask,
  input  logic              C,
  input  logic              V,
  input  logic              D,
  input  logic              Z,
  output logic [CW_W-1:0]   control_word,
  output logic              cw_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic [3:0]        halt_flags
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] iss_pc_q, iss_pc_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic              vld_q, vld_d;
  logic [3:0]        hflags_q, hflags_d;
  logic              step_pend_q, step_pend_d;

  logic [CW_W-1:0]   rd_data;
  logic [3:0]        flags;
  logic              prog_ok;
  logic              flag_hit;
  logic              issue;

  assign prog_ok = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_HALT);

  seq_prog_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CW_W   (CW_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (prog_we && prog_ok),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_C] = C;
    flags[FLAG_V] = V;
    flags[FLAG_D] = D;
    flags[FLAG_Z] = Z;
  end

  // Flags reflect the word that was on the bus during the previous cycle.
  assign flag_hit = vld_q && ((flag_mask & flags) != 4'b0000);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    iss_pc_d    = iss_pc_q;
    cw_d        = NOP_CW;
    vld_d       = 1'b0;
    hflags_d    = hflags_q;
    step_pend_d = step_pend_q;
    issue       = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      pc_d        = '0;
      hflags_d    = 4'b0000;
      step_pend_d = 1'b0;
    end else if (flag_hit) begin
      state_d     = ST_HALT;
      hflags_d    = flags;
      step_pend_d = 1'b0;
    end else if (run) begin
      state_d     = ST_RUN;
      pc_d        = '0;
      hflags_d    = 4'b0000;
      step_pend_d = 1'b0;
    end else if (step && prog_ok) begin
      state_d     = ST_STEP;
      pc_d        = '0;
      hflags_d    = 4'b0000;
      step_pend_d = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: issue = 1'b1;
        ST_STEP: begin
          // A step arriving on the issuing edge queues the following word.
          issue       = step_pend_q;
          step_pend_d = step_pend_q ? step : (step_pend_q | step);
        end
        default: issue = 1'b0;
      endcase

      if (issue) begin
        cw_d     = rd_data;
        vld_d    = 1'b1;
        iss_pc_d = pc_q;
        if (pc_q >= prog_len) begin
          state_d = ST_DONE;
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      iss_pc_q    <= '0;
      cw_q        <= NOP_CW;
      vld_q       <= 1'b0;
      hflags_q    <= 4'b0000;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iss_pc_q    <= iss_pc_d;
      cw_q        <= cw_d;
      vld_q       <= vld_d;
      hflags_q    <= hflags_d;
      step_pend_q <= step_pend_d;
    end
  end

  assign control_word = cw_q;
  assign cw_valid     = vld_q;
  assign pc           = vld_q ? iss_pc_q : pc_q;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign done         = (state_q == ST_DONE);
  assign halted       = (state_q == ST_HALT);
  assign halt_flags   = hflags_q;

endmodule
